// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the RAM-backed FIFO controller.
// Optional error reporting is enabled with the RAM_FIFO_ERR_EN macro.
package ram_fifo_ctrl_pkg;

  localparam logic RESET = 1'b0;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int fifo_ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

`ifdef RAM_FIFO_ERR_EN
  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_PUSH_FULL = 2'b01,
    ERR_POP_EMPTY = 2'b10
  } err_cause_e;
`endif

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping FIFO pointer with increment enable and synchronous clear.
// Used once for the write side and once for the read side.
module ram_fifo_ptr
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM: valid/ready push stream to
// RAM writes, FWFT pop stream from the combinational RAM read port.
// Define RAM_FIFO_ERR_EN to add the sticky err output and err_clr input.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 12,
  parameter int MEM_NUM   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [DATAWIDTH-1:0] push_data,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [DATAWIDTH-1:0] pop_data,
  output logic [ADDRWIDTH:0]   count,
  output logic                 ram_wen,
  output logic [ADDRWIDTH-1:0] ram_wAddr,
  output logic [DATAWIDTH-1:0] ram_wData,
  output logic                 ram_ren,
  output logic [ADDRWIDTH-1:0] ram_rAddr,
  input  logic [DATAWIDTH-1:0] ram_rData
`ifdef RAM_FIFO_ERR_EN
  ,
  input  logic                 err_clr,
  output logic                 err
`endif
);

  localparam int PW = fifo_ptr_w(ADDRWIDTH);
  localparam logic [PW-1:0] DEPTH = PW'(MEM_NUM);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push_fire;
  logic          pop_fire;

  assign empty = (wr_ptr == rd_ptr);
  // Occupancy equals DEPTH exactly when the address bits match and wrap bits differ.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH);

  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pop_data   = ram_rData;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    push_fire = 1'b0;
    pop_fire  = 1'b0;
    if (rst != RESET && !flush) begin
      push_fire = push_valid && !full;
      pop_fire  = pop_ready && !empty;
    end
  end

  assign ram_wen   = push_fire;
  assign ram_wAddr = wr_ptr[ADDRWIDTH-1:0];
  assign ram_wData = push_data;
  assign ram_ren   = 1'b1;
  assign ram_rAddr = rd_ptr[ADDRWIDTH-1:0];

  ram_fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push_fire),
    .ptr (wr_ptr)
  );

  ram_fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop_fire),
    .ptr (rd_ptr)
  );

`ifdef RAM_FIFO_ERR_EN
  err_cause_e cause;

  always_comb begin
    cause = ERR_NONE;
    if (push_valid && full) begin
      cause = ERR_PUSH_FULL;
    end else if (pop_ready && empty) begin
      cause = ERR_POP_EMPTY;
    end
  end

  // Set has priority over clear so a coincident violation is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      err <= 1'b0;
    end else if (cause != ERR_NONE) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`endif

endmodule
